bus_initiator: RTL and testbench

- Bus initiator (master) for the strobe/ack register bus used by the register-bank responders.
- Accepts commands from an upstream source on a valid/ready port and issues one single-cycle o_stb per bus beat.
- Holds o_addr, o_we and o_data stable until the beat's ack arrives, then returns captured read data or a write completion on a valid/ready response port.
- Supports incrementing read bursts and a per-beat ack timeout.

---
 rtl/bus_initiator_if.sv | 41 ++++
 rtl/bus_initiator.sv | 115 +++++++++++
 tb/tb_bus_initiator.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/bus_initiator_if.sv
// Upstream command port, strobe/ack register bus and response port of the bus initiator.
// master = initiator side; slave = command source, bus responder and response sink.
interface bus_initiator_if #(
  parameter int DATAW = 8,
  parameter int LENW  = 4
);
  logic             i_cmd_valid;
  logic             o_cmd_ready;
  logic             i_cmd_we;
  logic [7:0]       i_cmd_addr;
  logic [DATAW-1:0] i_cmd_data;
  logic [LENW-1:0]  i_cmd_len;

  logic             o_stb;
  logic             o_we;
  logic [7:0]       o_addr;
  logic [DATAW-1:0] o_data;
  logic             i_ack;
  logic [DATAW-1:0] i_data;

  logic             o_rsp_valid;
  logic             i_rsp_ready;
  logic [DATAW-1:0] o_rsp_data;
  logic             o_rsp_we;
  logic             o_rsp_err;
  logic             o_rsp_last;

  modport master (
    input  i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_data, i_cmd_len,
    input  i_ack, i_data, i_rsp_ready,
    output o_cmd_ready, o_stb, o_we, o_addr, o_data,
    output o_rsp_valid, o_rsp_data, o_rsp_we, o_rsp_err, o_rsp_last
  );

  modport slave (
    output i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_data, i_cmd_len,
    output i_ack, i_data, i_rsp_ready,
    input  o_cmd_ready, o_stb, o_we, o_addr, o_data,
    input  o_rsp_valid, o_rsp_data, o_rsp_we, o_rsp_err, o_rsp_last
  );
endinterface

// File: rtl/bus_initiator.sv
// Strobe/ack bus initiator with read bursts and per-beat ack timeout; cmd->stb 1 cycle, ack->rsp 1 cycle.
// One command in flight; the response is held until i_rsp_ready, and the next beat waits for it.
module bus_initiator #(
  parameter int DATAW   = 8,
  parameter int LENW    = 4,
  parameter int TIMEOUT = 16
) (
  input logic             i_clk,
  input logic             i_rst_n,
  bus_initiator_if.master bus
);
  typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e           state_q;
  logic             stb_q;
  logic             we_q;
  logic [7:0]       addr_q;
  logic [DATAW-1:0] data_q;
  logic [LENW-1:0]  beats_q;  // beats still to issue after the current one
  logic [7:0]       tmo_q;
  logic             rsp_valid_q;
  logic [DATAW-1:0] rsp_data_q;
  logic             rsp_we_q;
  logic             rsp_err_q;
  logic             rsp_last_q;

  logic [7:0]       addr_d;
  logic [LENW-1:0]  beats_d;

  assign addr_d  = addr_q + 8'd1;
  assign beats_d = beats_q - 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      beats_q     <= '0;
      tmo_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_cmd_valid) begin
            we_q    <= bus.i_cmd_we;
            addr_q  <= bus.i_cmd_addr;
            data_q  <= bus.i_cmd_data;
            beats_q <= bus.i_cmd_we ? '0 : bus.i_cmd_len;
            stb_q   <= 1'b1;
            state_q <= STROBE;
          end
        end
        STROBE: begin
          stb_q   <= 1'b0;
          tmo_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // an ack on the final timeout cycle still wins over the abort
          if (bus.i_ack) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= we_q ? '0 : bus.i_data;
            rsp_we_q    <= we_q;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= (beats_q == '0);
            state_q     <= RESP;
          end else if (tmo_q == TMO_LAST) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= '0;
            rsp_we_q    <= we_q;
            rsp_err_q   <= 1'b1;
            rsp_last_q  <= 1'b1;
            beats_q     <= '0;
            state_q     <= RESP;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        RESP: begin
          if (bus.i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (rsp_last_q) begin
              state_q <= IDLE;
            end else begin
              addr_q  <= addr_d;
              beats_q <= beats_d;
              stb_q   <= 1'b1;
              state_q <= STROBE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_cmd_ready = (state_q == IDLE) & i_rst_n;
  assign bus.o_stb       = stb_q;
  assign bus.o_we        = we_q;
  assign bus.o_addr      = addr_q;
  assign bus.o_data      = data_q;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_data  = rsp_data_q;
  assign bus.o_rsp_we    = rsp_we_q;
  assign bus.o_rsp_err   = rsp_err_q;
  assign bus.o_rsp_last  = rsp_last_q;
endmodule

// File: tb/tb_bus_initiator.sv
// Bench for bus_initiator: scripted and random commands against a beat-level reference model;
// the responder answers reads with addr^8'hFF after a chosen delay or never (timeout).
module tb_bus_initiator;
  localparam int DATAW   = 8;
  localparam int LENW    = 4;
  localparam int TIMEOUT = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bus_initiator_if #(.DATAW(DATAW), .LENW(LENW)) bif ();

  bus_initiator #(.DATAW(DATAW), .LENW(LENW), .TIMEOUT(TIMEOUT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bif)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {1'b0, bif.o_stb, bif.o_rsp_valid, bif.o_cmd_ready, bif.o_addr, bif.o_we,
            bif.o_data, bif.o_rsp_data, bif.o_rsp_err, bif.o_rsp_last, bif.o_rsp_we};
  endfunction

  // dly > 0 fixes the ack delay (cycles after the strobe) for every beat; > TIMEOUT means no ack.
  // dly == 0 picks it per beat. stall < 0 picks the response backpressure per beat.
  task automatic run_cmd(input bit we, input logic [7:0] addr, input logic [7:0] data,
                         input logic [3:0] len, input int dly, input int stall, input bit noise);
    int         beats, d, r, st;
    bit         err, last;
    logic [7:0] a, exp_d;
    beats = we ? 1 : int'(len) + 1;
    check("cmd_rdy", 32'(bif.o_cmd_ready), 32'd1);
    bif.i_cmd_valid = 1'b1;
    bif.i_cmd_we    = we;
    bif.i_cmd_addr  = addr;
    bif.i_cmd_data  = data;
    bif.i_cmd_len   = len;
    @(negedge clk);
    bif.i_cmd_valid = 1'b0;
    for (int i = 0; i < beats; i++) begin
      a = addr + 8'(i);
      check("stb", 32'(bif.o_stb), 32'd1);
      check("stb_bus", 32'({bif.o_we, bif.o_addr, bif.o_data}), 32'({we, a, data}));
      check("busy_rdy", 32'(bif.o_cmd_ready), 32'd0);
      if (dly > 0) d = dly;
      else if ($urandom_range(0, 11) == 0) d = TIMEOUT + 1;
      else d = int'($urandom_range(1, TIMEOUT));
      err = (d > TIMEOUT);
      r   = err ? TIMEOUT + 1 : d + 1;
      for (int t = 1; t <= r; t++) begin
        @(negedge clk);
        if (t < r)
          check("wait_hold", 32'({bif.o_rsp_valid, bif.o_stb, bif.o_we, bif.o_addr, bif.o_data}),
                32'({2'b00, we, a, data}));
        else
          check("rsp_vld", 32'(bif.o_rsp_valid), 32'd1);
        bif.i_ack  = (t == d) && (t < r);
        bif.i_data = we ? 8'($urandom) : (a ^ 8'hFF);
      end
      bif.i_ack = 1'b0;
      last  = err || (i == beats - 1);
      exp_d = (we || err) ? 8'h00 : (a ^ 8'hFF);
      check("rsp", 32'({bif.o_rsp_data, bif.o_rsp_we, bif.o_rsp_err, bif.o_rsp_last}),
            32'({exp_d, we, err, last}));
      st = (stall >= 0) ? stall : int'($urandom_range(0, 3));
      for (int k = 0; k < st; k++) begin
        if (noise) begin
          bif.i_ack       = 1'($urandom);
          bif.i_data      = 8'($urandom);
          bif.i_cmd_valid = 1'($urandom);
          bif.i_cmd_we    = 1'($urandom);
          bif.i_cmd_addr  = 8'($urandom);
        end
        @(negedge clk);
        check("bp_hold", 32'({bif.o_rsp_valid, bif.o_stb, bif.o_cmd_ready, bif.o_rsp_data,
                              bif.o_rsp_we, bif.o_rsp_err, bif.o_rsp_last, bif.o_addr}),
              32'({3'b100, exp_d, we, err, last, a}));
      end
      bif.i_ack       = 1'b0;
      bif.i_cmd_valid = 1'b0;
      bif.i_rsp_ready = 1'b1;
      @(negedge clk);
      bif.i_rsp_ready = 1'b0;
      check("hs_vld", 32'(bif.o_rsp_valid), 32'd0);
      if (last) begin
        check("done", 32'({bif.o_cmd_ready, bif.o_stb}), 32'({1'b1, 1'b0}));
        break;
      end
    end
  endtask

  task automatic reset_mid(input bit at_rsp);
    check("mid_rdy", 32'(bif.o_cmd_ready), 32'd1);
    bif.i_cmd_valid = 1'b1;
    bif.i_cmd_we    = 1'b0;
    bif.i_cmd_addr  = 8'h40;
    bif.i_cmd_data  = 8'h00;
    bif.i_cmd_len   = 4'd3;
    @(negedge clk);
    bif.i_cmd_valid = 1'b0;
    if (at_rsp) begin
      @(negedge clk);
      bif.i_ack  = 1'b1;
      bif.i_data = 8'hBF;
      @(negedge clk);
      bif.i_ack = 1'b0;
    end
    check("mid_pre", 32'({bif.o_stb, bif.o_rsp_valid}), at_rsp ? 32'd1 : 32'd2);
    #2 rst_n = 1'b0;
    #1 check("mid_rst", out_vec(), 32'd0);
    @(negedge clk);
    check("mid_rst_hold", out_vec(), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rel_rdy", 32'(bif.o_cmd_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.i_cmd_valid = 1'b0;
    bif.i_cmd_we    = 1'b0;
    bif.i_cmd_addr  = 8'h00;
    bif.i_cmd_data  = 8'h00;
    bif.i_cmd_len   = 4'd0;
    bif.i_ack       = 1'b0;
    bif.i_data      = 8'h00;
    bif.i_rsp_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", out_vec(), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rel_rdy", 32'(bif.o_cmd_ready), 32'd1);

    run_cmd(1'b1, 8'h12, 8'hA5, 4'd0, 2, 0, 1'b0);
    run_cmd(1'b0, 8'h20, 8'h00, 4'd3, 2, 0, 1'b0);
    run_cmd(1'b0, 8'hFE, 8'h5A, 4'd2, 2, 1, 1'b0);
    run_cmd(1'b0, 8'h33, 8'h00, 4'd0, TIMEOUT + 1, 0, 1'b0);
    run_cmd(1'b0, 8'h80, 8'h00, 4'd1, TIMEOUT, 0, 1'b0);
    run_cmd(1'b1, 8'h90, 8'hC3, 4'd7, TIMEOUT + 1, 2, 1'b1);
    run_cmd(1'b0, 8'h44, 8'h00, 4'd1, 3, 5, 1'b1);
    run_cmd(1'b0, 8'h60, 8'h00, 4'd4, 1, 0, 1'b0);
    reset_mid(1'b0);
    run_cmd(1'b1, 8'h55, 8'h66, 4'd0, 2, 0, 1'b0);
    reset_mid(1'b1);
    run_cmd(1'b1, 8'hAA, 8'h3C, 4'd2, 2, 0, 1'b0);
    for (int n = 0; n < 40; n++)
      run_cmd(1'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), 0, -1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
